// File: rtl/zsram_access_scheduler.sv
// Round-robin arbiter and strobe sequencer that shares a word-organised
// zero-second RAM array between two requesters (A and B).
module zsram_access_scheduler #(
  parameter int DEPTH         = 16,
  parameter int WIDTH         = 8,
  parameter int ADDR_W        = 4,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              Crystal50Mhz1,
  input  logic              ResetN,
  input  logic              ReqA,
  input  logic              WrA,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [WIDTH-1:0]  WDataA,
  output logic              AckA,
  output logic [WIDTH-1:0]  RDataA,
  input  logic              ReqB,
  input  logic              WrB,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [WIDTH-1:0]  WDataB,
  output logic              AckB,
  output logic [WIDTH-1:0]  RDataB,
  output logic [DEPTH-1:0]  CellWriteEdge,
  output logic [DEPTH-1:0]  CellReadEdge,
  output logic [WIDTH-1:0]  CellInputData,
  input  logic [WIDTH-1:0]  CellOutputData,
  output logic              Busy
);

  // state    | meaning
  // S_IDLE   | arbitrate; skipped for one cycle after HOLD (r_dead)
  // S_SETUP  | data bus driven, no strobe
  // S_STROBE | one strobe bit high for STROBE_CYCLES cycles
  // S_HOLD   | strobe low, data still driven, Ack to the winner
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

  state_t            r_state;
  logic              r_ptr_b;
  logic              r_sel_b;
  logic              r_wr;
  logic              r_dead;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_cnt;
  logic [DEPTH-1:0]  r_wedge;
  logic [DEPTH-1:0]  r_redge;
  logic [WIDTH-1:0]  r_cell_wdata;
  logic [WIDTH-1:0]  r_rdata_a;
  logic [WIDTH-1:0]  r_rdata_b;
  logic              r_ack_a;
  logic              r_ack_b;

  logic              w_grant_b;
  logic              w_in_range;
  logic              w_wr;
  logic [DEPTH-1:0]  w_dec;
  logic [WIDTH-1:0]  w_capture;

  assign w_grant_b = ReqB & (~ReqA | r_ptr_b);
  assign w_wr      = w_grant_b ? WrB : WrA;

  // Out-of-range addresses decode to all-zero, so no strobe ever fires for them.
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(r_addr) == i) w_dec[i] = 1'b1;
    end
  end

  assign w_in_range = |w_dec;
  assign w_capture  = w_in_range ? CellOutputData : '0;

  always_ff @(posedge Crystal50Mhz1 or negedge ResetN) begin
    if (!ResetN) begin
      r_state      <= S_IDLE;
      r_ptr_b      <= 1'b0;
      r_sel_b      <= 1'b0;
      r_wr         <= 1'b0;
      r_dead       <= 1'b0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_wedge      <= '0;
      r_redge      <= '0;
      r_cell_wdata <= '0;
      r_rdata_a    <= '0;
      r_rdata_b    <= '0;
      r_ack_a      <= 1'b0;
      r_ack_b      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // One dead cycle after HOLD keeps a requester that reacts to Ack
          // a cycle late from being granted a stale request.
          if (r_dead) begin
            r_dead <= 1'b0;
          end else if (ReqA | ReqB) begin
            r_sel_b      <= w_grant_b;
            r_ptr_b      <= ~w_grant_b;
            r_wr         <= w_wr;
            r_addr       <= w_grant_b ? AddrB : AddrA;
            r_cell_wdata <= w_wr ? (w_grant_b ? WDataB : WDataA) : '0;
            r_state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_wedge <= r_wr ? w_dec : '0;
          r_redge <= r_wr ? '0 : w_dec;
          r_cnt   <= CNT_LOAD;
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          if (r_cnt == 4'd0) begin
            r_wedge <= '0;
            r_redge <= '0;
            if (!r_wr && !r_sel_b) r_rdata_a <= w_capture;
            if (!r_wr &&  r_sel_b) r_rdata_b <= w_capture;
            r_ack_a <= ~r_sel_b;
            r_ack_b <= r_sel_b;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          r_ack_a      <= 1'b0;
          r_ack_b      <= 1'b0;
          r_cell_wdata <= '0;
          r_dead       <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign AckA          = r_ack_a;
  assign AckB          = r_ack_b;
  assign RDataA        = r_rdata_a;
  assign RDataB        = r_rdata_b;
  assign CellWriteEdge = r_wedge;
  assign CellReadEdge  = r_redge;
  assign CellInputData = r_cell_wdata;
  assign Busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_zsram_access_scheduler.sv
// Directed bench for zsram_access_scheduler: a default instance (16 words,
// 2-cycle strobe) plus a 12-word, 1-cycle-strobe instance for out-of-range reads.
module tb_zsram_access_scheduler;

  logic        clk;
  logic        rst_n;
  logic        req_a, wr_a, req_b, wr_b;
  logic [3:0]  addr_a, addr_b;
  logic [7:0]  wdata_a, wdata_b;
  logic        ack_a, ack_b;
  logic [7:0]  rdata_a, rdata_b;
  logic [15:0] wedge, redge;
  logic [7:0]  cin, cout, tb_cout, model_q;
  logic        busy;
  logic        use_model;

  logic        req_a1, wr_a1, req_b1, wr_b1;
  logic [3:0]  addr_a1, addr_b1;
  logic [7:0]  wdata_a1, wdata_b1;
  logic        ack_a1, ack_b1;
  logic [7:0]  rdata_a1, rdata_b1;
  logic [11:0] wedge1, redge1;
  logic [7:0]  cin1, cout1;
  logic        busy1;

  logic [7:0]  mem [16] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;

  zsram_access_scheduler dut0 (
    .Crystal50Mhz1(clk), .ResetN(rst_n),
    .ReqA(req_a), .WrA(wr_a), .AddrA(addr_a), .WDataA(wdata_a), .AckA(ack_a), .RDataA(rdata_a),
    .ReqB(req_b), .WrB(wr_b), .AddrB(addr_b), .WDataB(wdata_b), .AckB(ack_b), .RDataB(rdata_b),
    .CellWriteEdge(wedge), .CellReadEdge(redge), .CellInputData(cin),
    .CellOutputData(cout), .Busy(busy)
  );

  zsram_access_scheduler #(.DEPTH(12), .WIDTH(8), .ADDR_W(4), .STROBE_CYCLES(1)) dut1 (
    .Crystal50Mhz1(clk), .ResetN(rst_n),
    .ReqA(req_a1), .WrA(wr_a1), .AddrA(addr_a1), .WDataA(wdata_a1), .AckA(ack_a1), .RDataA(rdata_a1),
    .ReqB(req_b1), .WrB(wr_b1), .AddrB(addr_b1), .WDataB(wdata_b1), .AckB(ack_b1), .RDataB(rdata_b1),
    .CellWriteEdge(wedge1), .CellReadEdge(redge1), .CellInputData(cin1),
    .CellOutputData(cout1), .Busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural cell array used by the random mix.
  always_comb begin
    model_q = 8'h00;
    for (int i = 0; i < 16; i++) if (redge[i]) model_q = mem[i];
  end

  always @(posedge clk) begin
    if (use_model) begin
      for (int i = 0; i < 16; i++) if (wedge[i]) mem[i] <= cin;
    end
  end

  assign cout  = use_model ? model_q : tb_cout;
  assign cout1 = 8'h77;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_a = 0; wr_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; wr_b = 0; addr_b = 0; wdata_b = 0;
    req_a1 = 0; wr_a1 = 0; addr_a1 = 0; wdata_a1 = 0;
    req_b1 = 0; wr_b1 = 0; addr_b1 = 0; wdata_b1 = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ack_a, ack_b, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000", {ack_a, ack_b, busy});
    end
    checks++;
    if ({wedge, redge} !== 32'h0) begin
      errors++; $display("FAIL reset_strobes got %h exp 0", {wedge, redge});
    end
    checks++;
    if ({cin, rdata_a, rdata_b} !== 24'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {cin, rdata_a, rdata_b});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_a();
    req_a = 1; wr_a = 1; addr_a = 4'd3; wdata_a = 8'hA5;
    for (int c = 0; c <= 6; c++) begin
      checks++;
      if (wedge !== ((c == 2 || c == 3) ? 16'h0008 : 16'h0000)) begin
        errors++; $display("FAIL wr_a_wedge c%0d got %h", c, wedge);
      end
      checks++;
      if (cin !== ((c >= 1 && c <= 4) ? 8'hA5 : 8'h00)) begin
        errors++; $display("FAIL wr_a_cin c%0d got %h", c, cin);
      end
      checks++;
      if (ack_a !== (c == 4)) begin
        errors++; $display("FAIL wr_a_ack c%0d got %b", c, ack_a);
      end
      checks++;
      if (redge !== 16'h0) begin
        errors++; $display("FAIL wr_a_redge c%0d got %h exp 0", c, redge);
      end
      checks++;
      if (busy !== (c >= 1 && c <= 4)) begin
        errors++; $display("FAIL wr_a_busy c%0d got %b", c, busy);
      end
      if (c == 4) req_a = 0;
      step();
    end
  endtask

  task automatic test_read_b();
    tb_cout = 8'h3C;
    req_b = 1; wr_b = 0; addr_b = 4'd15; wdata_b = 8'hFF;
    for (int c = 0; c <= 6; c++) begin
      checks++;
      if (redge !== ((c == 2 || c == 3) ? 16'h8000 : 16'h0000)) begin
        errors++; $display("FAIL rd_b_redge c%0d got %h", c, redge);
      end
      checks++;
      if (ack_b !== (c == 4) || ack_a !== 1'b0) begin
        errors++; $display("FAIL rd_b_ack c%0d got b=%b a=%b", c, ack_b, ack_a);
      end
      checks++;
      if (rdata_b !== ((c >= 4) ? 8'h3C : 8'h00)) begin
        errors++; $display("FAIL rd_b_rdata c%0d got %h", c, rdata_b);
      end
      checks++;
      if (rdata_a !== 8'h00 || wedge !== 16'h0 || cin !== 8'h00) begin
        errors++; $display("FAIL rd_b_side c%0d got rda=%h we=%h cin=%h", c, rdata_a, wedge, cin);
      end
      if (c == 4) req_b = 0;
      step();
    end
    tb_cout = 8'h00;
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_we;
    test_reset();
    req_a = 1; wr_a = 1; addr_a = 4'd1; wdata_a = 8'h11;
    req_b = 1; wr_b = 1; addr_b = 4'd2; wdata_b = 8'h22;
    for (int c = 0; c <= 18; c++) begin
      exp_we = 16'h0;
      if (c == 2 || c == 3 || c == 14 || c == 15) exp_we = 16'h0002;
      if (c == 8 || c == 9) exp_we = 16'h0004;
      checks++;
      if (wedge !== exp_we) begin
        errors++; $display("FAIL rr_wedge c%0d got %h exp %h", c, wedge, exp_we);
      end
      checks++;
      if (ack_a !== (c == 4 || c == 16)) begin
        errors++; $display("FAIL rr_ack_a c%0d got %b", c, ack_a);
      end
      checks++;
      if (ack_b !== (c == 10)) begin
        errors++; $display("FAIL rr_ack_b c%0d got %b", c, ack_b);
      end
      if (c == 16) begin req_a = 0; req_b = 0; end
      step();
    end
  endtask

  task automatic test_out_of_range();
    req_a1 = 1; wr_a1 = 0; addr_a1 = 4'd13;
    for (int c = 0; c <= 5; c++) begin
      checks++;
      if ({wedge1, redge1} !== 24'h0) begin
        errors++; $display("FAIL oor_strobe c%0d got %h exp 0", c, {wedge1, redge1});
      end
      checks++;
      if (ack_a1 !== (c == 3)) begin
        errors++; $display("FAIL oor_ack c%0d got %b", c, ack_a1);
      end
      checks++;
      if (busy1 !== (c >= 1 && c <= 3)) begin
        errors++; $display("FAIL oor_busy c%0d got %b", c, busy1);
      end
      checks++;
      if (rdata_a1 !== 8'h00) begin
        errors++; $display("FAIL oor_rdata c%0d got %h exp 00", c, rdata_a1);
      end
      if (c == 3) req_a1 = 0;
      step();
    end
  endtask

  task automatic test_reset_mid_strobe();
    req_a = 1; wr_a = 1; addr_a = 4'd5; wdata_a = 8'hC3;
    step(); step();
    checks++;
    if (wedge !== 16'h0020) begin
      errors++; $display("FAIL rst_mid_pre got %h exp 0020", wedge);
    end
    rst_n = 1'b0;
    req_a = 0;
    #1;
    checks++;
    if (wedge !== 16'h0 || busy !== 1'b0 || ack_a !== 1'b0 || cin !== 8'h00) begin
      errors++; $display("FAIL rst_mid_async got we=%h busy=%b ack=%b cin=%h", wedge, busy, ack_a, cin);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (ack_a !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_mid_noack c%0d got ack=%b busy=%b", c, ack_a, busy);
      end
      step();
    end
    req_a = 1; wr_a = 1; addr_a = 4'd5; wdata_a = 8'h5A;
    for (int c = 0; c <= 6; c++) begin
      checks++;
      if (wedge !== ((c == 2 || c == 3) ? 16'h0020 : 16'h0000)) begin
        errors++; $display("FAIL rst_reissue_wedge c%0d got %h", c, wedge);
      end
      checks++;
      if (ack_a !== (c == 4)) begin
        errors++; $display("FAIL rst_reissue_ack c%0d got %b", c, ack_a);
      end
      if (c == 4) req_a = 0;
      step();
    end
  endtask

  task automatic test_random_mix();
    logic [7:0]  sb [16];
    logic [31:0] v;
    logic        pa, pb;
    int          cyc, wc;
    for (int i = 0; i < 16; i++) sb[i] = 8'h00;
    test_reset();
    use_model = 1'b1;
    cyc = 0;
    while (cyc < 200) begin
      pa = 1'($urandom_range(0, 1));
      pb = 1'($urandom_range(0, 1));
      if (pa) begin
        wr_a = 1'($urandom_range(0, 1)); addr_a = 4'($urandom_range(0, 15));
        wdata_a = 8'($urandom_range(0, 255)); req_a = 1;
      end
      if (pb) begin
        wr_b = 1'($urandom_range(0, 1)); addr_b = 4'($urandom_range(0, 15));
        wdata_b = 8'($urandom_range(0, 255)); req_b = 1;
      end
      wc = 0;
      do begin
        step();
        cyc++; wc++;
        v = {wedge, redge};
        checks++;
        if ((v & (v - 32'd1)) !== 32'h0) begin
          errors++; $display("FAIL rnd_onehot cyc%0d got %h", cyc, v);
        end
        if (ack_a) begin
          checks++;
          if (!pa) begin
            errors++; $display("FAIL rnd_ack_a cyc%0d got 1 exp 0", cyc);
          end else if (wr_a) begin
            sb[addr_a] = wdata_a;
          end else if (rdata_a !== sb[addr_a]) begin
            errors++; $display("FAIL rnd_rdata_a addr%0d got %h exp %h", addr_a, rdata_a, sb[addr_a]);
          end
          req_a = 0; pa = 0;
        end
        if (ack_b) begin
          checks++;
          if (!pb) begin
            errors++; $display("FAIL rnd_ack_b cyc%0d got 1 exp 0", cyc);
          end else if (wr_b) begin
            sb[addr_b] = wdata_b;
          end else if (rdata_b !== sb[addr_b]) begin
            errors++; $display("FAIL rnd_rdata_b addr%0d got %h exp %h", addr_b, rdata_b, sb[addr_b]);
          end
          req_b = 0; pb = 0;
        end
      end while ((pa || pb) && wc < 40);
      if (pa || pb) begin
        checks++; errors++;
        $display("FAIL rnd_timeout cyc%0d pending a=%b b=%b", cyc, pa, pb);
        req_a = 0; req_b = 0;
      end
    end
    use_model = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    use_model = 1'b0;
    tb_cout   = 8'h00;
    test_reset();
    test_write_a();
    step();
    test_read_b();
    step();
    test_round_robin();
    step();
    test_out_of_range();
    test_reset_mid_strobe();
    step();
    test_random_mix();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
